// File: rtl/cnn_layer_accel_weight_seq_table_loader.sv
// Loads weight-sequence pairs from the config stream into table addresses 0..N-1
// over a valid/ready handshake; reports busy/done/error to the layer controller.
module cnn_layer_accel_weight_seq_table_loader #(
    parameter int unsigned C_SEQ_WIDTH  = 5,
    parameter int unsigned C_NUM_SEQ    = 5,
    parameter int unsigned C_ADDR_WIDTH = $clog2(C_NUM_SEQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_start,
    input  logic [C_ADDR_WIDTH:0]   cfg_num_values,
    input  logic                    seq_in_valid,
    output logic                    seq_in_ready,
    input  logic [C_SEQ_WIDTH-1:0]  seq_in0,
    input  logic [C_SEQ_WIDTH-1:0]  seq_in1,
    output logic                    wren,
    output logic [C_ADDR_WIDTH-1:0] wrAddr,
    output logic [C_SEQ_WIDTH-1:0]  wrData0,
    output logic [C_SEQ_WIDTH-1:0]  wrData1,
    output logic                    load_busy,
    output logic                    load_done,
    output logic                    load_err
);

    localparam logic [C_ADDR_WIDTH:0] MaxNum = (C_ADDR_WIDTH + 1)'(C_NUM_SEQ);

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e                  state_q, state_d;
    logic [C_ADDR_WIDTH:0]   count_q, count_d;
    logic [C_ADDR_WIDTH:0]   num_q, num_d;
    logic                    wren_q, wren_d;
    logic                    err_q, err_d;
    logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [C_SEQ_WIDTH-1:0]  data0_q, data0_d;
    logic [C_SEQ_WIDTH-1:0]  data1_q, data1_d;
    logic                    xfer;

    assign xfer = seq_in_valid && (state_q == StLoad);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        num_d   = num_q;
        wren_d  = 1'b0;
        err_d   = 1'b0;
        addr_d  = addr_q;
        data0_d = data0_q;
        data1_d = data1_q;
        unique case (state_q)
            StIdle: begin
                if (cfg_start) begin
                    if (cfg_num_values != '0 && cfg_num_values <= MaxNum) begin
                        num_d   = cfg_num_values;
                        count_d = '0;
                        state_d = StLoad;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (xfer) begin
                    wren_d  = 1'b1;
                    addr_d  = count_q[C_ADDR_WIDTH-1:0];
                    data0_d = seq_in0;
                    data1_d = seq_in1;
                    count_d = count_q + 1'b1;
                    // Final beat: DONE lines up with the last registered write.
                    if (count_q == num_q - 1'b1) begin
                        state_d = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            count_q <= '0;
            num_q   <= '0;
            wren_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            data0_q <= '0;
            data1_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            num_q   <= num_d;
            wren_q  <= wren_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
        end
    end

    assign seq_in_ready = (state_q == StLoad);
    assign load_busy    = (state_q == StLoad) || (state_q == StDone);
    assign load_done    = (state_q == StDone);
    assign load_err     = err_q;
    assign wren         = wren_q;
    assign wrAddr       = addr_q;
    assign wrData0      = data0_q;
    assign wrData1      = data1_q;

endmodule

// File: tb/tb_cnn_layer_accel_weight_seq_table_loader.sv
// Randomised self-checking bench for the weight-sequence table loader against a
// transfer-counting reference model.
module tb_cnn_layer_accel_weight_seq_table_loader;

    localparam int SW = 5;
    localparam int NS = 5;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_start;
    logic [AW:0]   cfg_num_values;
    logic          seq_in_valid;
    logic          seq_in_ready;
    logic [SW-1:0] seq_in0, seq_in1;
    logic          wren;
    logic [AW-1:0] wrAddr;
    logic [SW-1:0] wrData0, wrData1;
    logic          load_busy, load_done, load_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [SW-1:0] p0 [NS];
    logic [SW-1:0] p1 [NS];
    bit            vpat [6];

    cnn_layer_accel_weight_seq_table_loader #(
        .C_SEQ_WIDTH (SW),
        .C_NUM_SEQ   (NS),
        .C_ADDR_WIDTH(AW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_start     (cfg_start),
        .cfg_num_values(cfg_num_values),
        .seq_in_valid  (seq_in_valid),
        .seq_in_ready  (seq_in_ready),
        .seq_in0       (seq_in0),
        .seq_in1       (seq_in1),
        .wren          (wren),
        .wrAddr        (wrAddr),
        .wrData0       (wrData0),
        .wrData1       (wrData1),
        .load_busy     (load_busy),
        .load_done     (load_done),
        .load_err      (load_err)
    );

    always #5 clk = ~clk;

    // Reference: ready while fewer than n transfers have happened; each transfer k
    // appears as a write to addr k one cycle later; done rides on the final write.
    // mode 0: valid always, 1: vpat then always, 2: random valid.
    task automatic run_load(input int n, input int mode, input int restart_at, input string tag);
        int            xfers = 0;
        int            cyc   = 0;
        bit            prev_x = 0;
        bit            fin    = 0;
        bit            v;
        bit            exp_ready, exp_done;
        logic [SW-1:0] l0 = '0, l1 = '0;
        @(negedge clk);
        cfg_start = 1'b1; cfg_num_values = (AW+1)'(n); seq_in_valid = 1'b0;
        @(negedge clk);
        cfg_start = 1'b0;
        while (!fin && cyc < 100) begin
            exp_ready = (xfers < n);
            exp_done  = prev_x && (xfers == n);
            n_checks += 5;
            if (seq_in_ready !== exp_ready) begin
                n_fail++; $display("FAIL %s ready cyc%0d: got %b want %b", tag, cyc, seq_in_ready, exp_ready);
            end
            if (wren !== prev_x) begin
                n_fail++; $display("FAIL %s wren cyc%0d: got %b want %b", tag, cyc, wren, prev_x);
            end
            if (load_done !== exp_done) begin
                n_fail++; $display("FAIL %s done cyc%0d: got %b want %b", tag, cyc, load_done, exp_done);
            end
            if (load_busy !== (exp_ready || exp_done)) begin
                n_fail++; $display("FAIL %s busy cyc%0d: got %b want %b", tag, cyc, load_busy, exp_ready || exp_done);
            end
            if (load_err !== 1'b0) begin
                n_fail++; $display("FAIL %s err cyc%0d: got %b want 0", tag, cyc, load_err);
            end
            if (prev_x) begin
                n_checks++;
                if (wrAddr !== AW'(xfers - 1) || wrData0 !== l0 || wrData1 !== l1) begin
                    n_fail++;
                    $display("FAIL %s write cyc%0d: got a%0d %0d/%0d want a%0d %0d/%0d",
                             tag, cyc, wrAddr, wrData0, wrData1, xfers - 1, l0, l1);
                end
            end
            if (exp_done) begin
                fin = 1;
                // Idle cycle: valid offered but must not be consumed.
                seq_in_valid = 1'b1; seq_in0 = SW'($urandom); seq_in1 = SW'($urandom);
            end else begin
                cfg_start = (cyc == restart_at);
                cfg_num_values = cfg_start ? 4'd2 : (AW+1)'(n);
                case (mode)
                    0:       v = 1'b1;
                    1:       v = (cyc < 6) ? vpat[cyc] : 1'b1;
                    default: v = ($urandom_range(0, 3) != 0);
                endcase
                seq_in_valid = v;
                seq_in0 = (v && xfers < n) ? p0[xfers] : SW'($urandom);
                seq_in1 = (v && xfers < n) ? p1[xfers] : SW'($urandom);
                prev_x = v && exp_ready;
                if (prev_x) begin
                    l0 = p0[xfers]; l1 = p1[xfers]; xfers++;
                end
            end
            cyc++;
            @(negedge clk);
            cfg_start = 1'b0;
        end
        n_checks++;
        if (!fin) begin
            n_fail++; $display("FAIL %s timeout: got %0d transfers want %0d", tag, xfers, n);
        end else if (seq_in_ready || load_busy || wren || load_done || load_err ||
                     wrAddr !== AW'(n - 1) || wrData0 !== l0 || wrData1 !== l1) begin
            n_fail++;
            $display("FAIL %s idle-after: got rdy%b busy%b wren%b done%b err%b a%0d %0d/%0d want 0s a%0d %0d/%0d",
                     tag, seq_in_ready, load_busy, wren, load_done, load_err,
                     wrAddr, wrData0, wrData1, n - 1, l0, l1);
        end
        seq_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({seq_in_ready, wren, wrAddr, wrData0, wrData1, load_busy, load_done, load_err} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: got rdy%b wren%b a%0d %0d/%0d busy%b done%b err%b want all 0",
                     seq_in_ready, wren, wrAddr, wrData0, wrData1, load_busy, load_done, load_err);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({seq_in_ready, wren, load_busy, load_done, load_err} !== '0) begin
            n_fail++; $display("FAIL reset idle: got nonzero control outputs want 0");
        end
    endtask

    task automatic test_full_load();
        logic [SW-1:0] a0 [NS] = '{7, 8, 9, 0, 1};
        logic [SW-1:0] a1 [NS] = '{4, 5, 6, 2, 3};
        p0 = a0; p1 = a1;
        run_load(5, 0, -1, "full_load");
    endtask

    task automatic test_bubbles();
        for (int i = 0; i < NS; i++) begin p0[i] = SW'($urandom); p1[i] = SW'($urandom); end
        vpat = '{1, 0, 0, 1, 0, 1};
        run_load(3, 1, -1, "bubbles");
    endtask

    task automatic test_bad_config();
        int bad [4];
        bad = '{0, 6, 7 + $urandom_range(0, 8), 15};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cfg_start = 1'b1; cfg_num_values = (AW+1)'(bad[i]); seq_in_valid = 1'b1;
            @(negedge clk);
            cfg_start = 1'b0;
            n_checks += 2;
            if (load_err !== 1'b1) begin
                n_fail++; $display("FAIL bad_cfg n=%0d err: got %b want 1", bad[i], load_err);
            end
            if ({load_busy, seq_in_ready, wren, load_done} !== 4'b0) begin
                n_fail++; $display("FAIL bad_cfg n=%0d ctl: got %b want 0000", bad[i],
                                   {load_busy, seq_in_ready, wren, load_done});
            end
            @(negedge clk);
            n_checks++;
            if ({load_err, load_busy, wren} !== 3'b0) begin
                n_fail++; $display("FAIL bad_cfg n=%0d pulse: got %b want 000", bad[i],
                                   {load_err, load_busy, wren});
            end
        end
        seq_in_valid = 1'b0;
    endtask

    task automatic test_start_ignored();
        for (int i = 0; i < NS; i++) begin p0[i] = SW'($urandom); p1[i] = SW'($urandom); end
        run_load(4, 0, 1, "start_ignored");
    endtask

    task automatic test_reset_mid_load();
        @(negedge clk);
        cfg_start = 1'b1; cfg_num_values = 4'd5;
        @(negedge clk);
        cfg_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            seq_in_valid = 1'b1; seq_in0 = SW'($urandom) | 5'd1; seq_in1 = SW'($urandom) | 5'd1;
            @(negedge clk);
        end
        seq_in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({seq_in_ready, wren, wrAddr, wrData0, wrData1, load_busy, load_done, load_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid outputs: got rdy%b wren%b a%0d %0d/%0d busy%b want all 0",
                     seq_in_ready, wren, wrAddr, wrData0, wrData1, load_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        p0[0] = SW'($urandom); p1[0] = SW'($urandom);
        run_load(1, 0, -1, "reset_reload");
    endtask

    task automatic test_single();
        p0[0] = 5'd31; p1[0] = 5'd0;
        run_load(1, 0, -1, "single");
    endtask

    task automatic test_random_loads();
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < NS; i++) begin p0[i] = SW'($urandom); p1[i] = SW'($urandom); end
            run_load($urandom_range(1, NS), 2, $urandom_range(0, 1) ? int'($urandom_range(0, 3)) : -1,
                     "random");
        end
    endtask

    initial begin
        rst_n = 1'b0; cfg_start = 1'b0; cfg_num_values = '0;
        seq_in_valid = 1'b0; seq_in0 = '0; seq_in1 = '0;
        test_reset();
        test_full_load();
        test_bubbles();
        test_bad_config();
        test_start_ignored();
        test_reset_mid_load();
        test_single();
        test_random_loads();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
